// File: rtl/counter_cmd_ctrl.sv
// Pushbutton front end for the up/down counter: synchronise, debounce and edge-detect
// three buttons, then issue single-cycle enable/dec/load commands with hold-to-repeat.
module counter_cmd_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 8,
   parameter int unsigned REPEAT_PERIOD   = 4,
   parameter int unsigned TW              = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_load,
   output logic enable,
   output logic dec,
   output logic load,
   output logic holding
);

   localparam int unsigned NB = 3;
   localparam int unsigned UP = 0;
   localparam int unsigned DN = 1;
   localparam int unsigned LD = 2;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

   logic [NB-1:0] raw;
   logic [NB-1:0] sync1, sync2;
   logic [NB-1:0] deb, deb_d1;
   logic [NB-1:0] rise;
   logic [TW-1:0] dcnt [NB];

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [TW-1:0] thresh;
   logic          dir, dir_n;
   logic          dir_held, opp_held;
   logic          en_c, dec_c, ld_c;

   assign raw  = {btn_load, btn_down, btn_up};
   assign rise = deb & ~deb_d1;

   // Two-flop synchroniser plus debounce counter; a differing sample run commits
   // on the edge after the count completes, and any agreeing sample restarts it.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         deb_d1 <= '0;
         for (int i = 0; i < NB; i++) dcnt[i] <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         deb_d1 <= deb;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] != deb[i]) begin
               if (dcnt[i] == TW'(DEBOUNCE_CYCLES)) begin
                  deb[i]  <= sync2[i];
                  dcnt[i] <= '0;
               end else begin
                  dcnt[i] <= dcnt[i] + TW'(1);
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         dir     <= 1'b0;
         enable  <= 1'b0;
         dec     <= 1'b0;
         load    <= 1'b0;
         holding <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         dir     <= dir_n;
         enable  <= en_c;
         dec     <= dec_c;
         load    <= ld_c;
         holding <= (state_n == DELAY) || (state_n == REPEAT);
      end
   end

   assign dir_held = dir ? deb[DN] : deb[UP];
   assign opp_held = dir ? deb[UP] : deb[DN];
   assign thresh   = (state == DELAY) ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1);

   // Next state and command generation; load always wins over a count pulse.
   always_comb begin
      state_n = state;
      timer_n = timer;
      dir_n   = dir;
      en_c    = 1'b0;
      dec_c   = 1'b0;
      ld_c    = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (rise[LD]) begin
               ld_c    = 1'b1;
               state_n = LOCK;
            end else if (rise[UP] && !deb[DN]) begin
               en_c    = 1'b1;
               dir_n   = 1'b0;
               state_n = DELAY;
            end else if (rise[DN] && !deb[UP]) begin
               en_c    = 1'b1;
               dec_c   = 1'b1;
               dir_n   = 1'b1;
               state_n = DELAY;
            end else if (rise[UP] || rise[DN]) begin
               state_n = LOCK;
            end
         end
         DELAY, REPEAT: begin
            if (rise[LD]) begin
               ld_c    = 1'b1;
               timer_n = '0;
               state_n = LOCK;
            end else if (!dir_held) begin
               timer_n = '0;
               state_n = IDLE;
            end else if (opp_held) begin
               timer_n = '0;
               state_n = LOCK;
            end else if (timer == thresh) begin
               en_c    = 1'b1;
               dec_c   = dir;
               timer_n = '0;
               state_n = REPEAT;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         LOCK: begin
            timer_n = '0;
            if (deb == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl: cycle-numbered button scripts checked against
// hand-derived pulse positions (latency 7 at the default parameters).
module tb_counter_cmd_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
   logic enable, dec, load, holding;

   int nvec = 0;
   int nerr = 0;
   int cyc  = -1;

   counter_cmd_ctrl #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .TW(16)
   ) dut (
      .clock(clock), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
      .enable(enable), .dec(dec), .load(load), .holding(holding)
   );

   always #5 clock = ~clock;

   // Advance to one time unit after the next rising edge; cyc names that cycle.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   // Clean reset with buttons released; leaves the bench just before edge 0.
   task automatic restart();
      btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      repeat (4) tick();
      cyc = -1;
   endtask

   initial begin
      restart();
      chk("rst_enable",  enable,  1'b0);
      chk("rst_dec",     dec,     1'b0);
      chk("rst_load",    load,    1'b0);
      chk("rst_holding", holding, 1'b0);

      // Glitch: three cycles high must never reach the counter.
      btn_up = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         chk("glitch_enable",  enable,  1'b0);
         chk("glitch_holding", holding, 1'b0);
         if (c == 2) btn_up = 1'b0;
      end

      // Single tap, high for cycles 0..5: one pulse at 7, release seen at 13.
      restart();
      btn_up = 1'b1;
      for (int c = 0; c < 25; c++) begin
         tick();
         chk("tap_enable", enable, (c == 7));
         chk("tap_dec",    dec,    1'b0);
         if (c < 7 || c >= 13) chk("tap_holding_lo", holding, 1'b0);
         if (c >= 8 && c < 13) chk("tap_holding_hi", holding, 1'b1);
         if (c == 5) btn_up = 1'b0;
      end

      // Auto-repeat down, held for cycles 0..29.
      restart();
      btn_down = 1'b1;
      for (int c = 0; c < 50; c++) begin
         logic e;
         tick();
         e = (c inside {7, 15, 19, 23, 27, 31, 35});
         chk("rep_enable", enable, e);
         chk("rep_dec",    dec,    e);
         chk("rep_load",   load,   1'b0);
         if (c >= 37) chk("rep_holding_lo", holding, 1'b0);
         if (c == 29) btn_down = 1'b0;
      end

      // Load at 20 pre-empts the repeat pulse due at 27; LOCK until both released.
      restart();
      btn_up = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         chk("ldp_enable", enable, (c inside {7, 15, 19, 23}));
         chk("ldp_dec",    dec,    1'b0);
         chk("ldp_load",   load,   (c == 27));
         if (c >= 8 && c < 27) chk("ldp_holding_hi", holding, 1'b1);
         if (c >= 27)          chk("ldp_holding_lo", holding, 1'b0);
         if (c == 19) btn_load = 1'b1;
         if (c == 39) begin btn_up = 1'b0; btn_load = 1'b0; end
      end

      // Conflict: up+down together give nothing; a later up tap gives one pulse at 48.
      restart();
      btn_up = 1'b1; btn_down = 1'b1;
      for (int c = 0; c < 62; c++) begin
         tick();
         chk("cfl_enable", enable, (c == 48));
         chk("cfl_dec",    dec,    1'b0);
         chk("cfl_load",   load,   1'b0);
         if (c < 48 || c >= 54) chk("cfl_holding_lo", holding, 1'b0);
         if (c >= 49 && c < 54) chk("cfl_holding_hi", holding, 1'b1);
         if (c == 14) begin btn_up = 1'b0; btn_down = 1'b0; end
         if (c == 40) btn_up = 1'b1;
         if (c == 46) btn_up = 1'b0;
      end

      // Reset at cycles 18-19 mid-repeat; re-debounce yields a pulse at 27, repeat restarts.
      restart();
      btn_up = 1'b1;
      for (int c = 0; c < 46; c++) begin
         tick();
         chk("rmr_enable", enable, (c inside {7, 15, 27, 35, 39, 43}));
         chk("rmr_dec",    dec,    1'b0);
         chk("rmr_load",   load,   1'b0);
         if ((c >= 8 && c < 18) || c >= 28) chk("rmr_holding_hi", holding, 1'b1);
         if (c >= 18 && c < 27)             chk("rmr_holding_lo", holding, 1'b0);
         if (c == 17) reset = 1'b1;
         if (c == 19) reset = 1'b0;
      end
      btn_up = 1'b0;
      repeat (12) tick();
      chk("end_holding", holding, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
